// File: rtl/dram_bank_timing_ctrl_if.sv
// Request/issue/status bundle between the DRAM scheduler, the bank timing gate and the encoder.
interface dram_bank_timing_ctrl_if #(
    parameter int unsigned NUM_BANKS = 16,
    parameter int unsigned ROW_BITS  = 15
) ();
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    // Scheduler request channel
    logic                 req_valid;
    logic [1:0]           req_cmd;
    logic [BANK_W-1:0]    req_bank;
    logic [ROW_BITS-1:0]  req_row;
    logic                 req_ready;

    // Registered command strobe towards the encoder/PHY
    logic                 issue_valid;
    logic [2:0]           issue_cmd;
    logic [BANK_W-1:0]    issue_bank;
    logic [ROW_BITS-1:0]  issue_row;

    // Status
    logic [NUM_BANKS-1:0] bank_open;
    logic                 ref_pending;
    logic                 ref_busy;
    logic                 err_illegal;

    modport master (
        output req_valid, req_cmd, req_bank, req_row,
        input  req_ready, issue_valid, issue_cmd, issue_bank, issue_row,
        input  bank_open, ref_pending, ref_busy, err_illegal
    );

    modport slave (
        input  req_valid, req_cmd, req_bank, req_row,
        output req_ready, issue_valid, issue_cmd, issue_bank, issue_row,
        output bank_open, ref_pending, ref_busy, err_illegal
    );
endinterface

// File: rtl/dram_bank_timing_ctrl.sv
// Multi-bank DRAM command timing gate: per-bank open state and timing counters,
// plus the periodic refresh schedule. Commands are issued one cycle after handshake.
module dram_bank_timing_ctrl #(
    parameter int unsigned NUM_BANKS = 16,
    parameter int unsigned ROW_BITS  = 15,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned T_RCD     = 10,
    parameter int unsigned T_RAS     = 10,
    parameter int unsigned T_RP      = 10,
    parameter int unsigned T_RC      = 20,
    parameter int unsigned T_RTP     = 4,
    parameter int unsigned T_WREC    = 26,
    parameter int unsigned T_REFI    = 250,
    parameter int unsigned T_RFC     = 172
) (
    input logic                    CLK,
    input logic                    nRST,
    dram_bank_timing_ctrl_if.slave bus
);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [1:0] CmdAct = 2'd0;
    localparam logic [1:0] CmdRd  = 2'd1;
    localparam logic [1:0] CmdWr  = 2'd2;
    localparam logic [2:0] IssRef = 3'd4;

    localparam logic [1:0] StIdle       = 2'd0;
    localparam logic [1:0] StPending    = 2'd1;
    localparam logic [1:0] StRefreshing = 2'd2;

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRcd    = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] TRas    = CNT_W'(T_RAS);
    localparam logic [CNT_W-1:0] TRp     = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] TRc     = CNT_W'(T_RC);
    localparam logic [CNT_W-1:0] TRtp    = CNT_W'(T_RTP);
    localparam logic [CNT_W-1:0] TWrec   = CNT_W'(T_WREC);
    localparam logic [CNT_W-1:0] TRefiM1 = CNT_W'(T_REFI - 1);
    localparam logic [CNT_W-1:0] TRfcM1  = CNT_W'(T_RFC - 1);

    // Per-bank state
    logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
    logic [CNT_W-1:0]     cnt_act_q [NUM_BANKS];
    logic [CNT_W-1:0]     cnt_act_d [NUM_BANKS];
    logic [CNT_W-1:0]     cnt_pre_q [NUM_BANKS];
    logic [CNT_W-1:0]     cnt_pre_d [NUM_BANKS];
    logic [CNT_W-1:0]     cnt_rd_q  [NUM_BANKS];
    logic [CNT_W-1:0]     cnt_rd_d  [NUM_BANKS];
    logic [CNT_W-1:0]     cnt_wr_q  [NUM_BANKS];
    logic [CNT_W-1:0]     cnt_wr_d  [NUM_BANKS];

    // Refresh schedule
    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     refi_q, refi_d;
    logic [CNT_W-1:0]     rfc_q, rfc_d;

    // Issue register
    logic                 issue_valid_q, issue_valid_d;
    logic [2:0]           issue_cmd_q, issue_cmd_d;
    logic [BANK_W-1:0]    issue_bank_q, issue_bank_d;
    logic [ROW_BITS-1:0]  issue_row_q, issue_row_d;
    logic                 err_illegal_q, err_illegal_d;

    // Request decode
    logic [BANK_W-1:0]    bank;
    logic                 legal;
    logic                 timing_ok;
    logic                 all_idle;
    logic                 ref_go;
    logic                 stall;
    logic                 accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + 1'b1;
    endfunction

    // Legality and timing check of the presented request against pre-edge counters
    always_comb begin
        bank      = bus.req_bank;
        legal     = 1'b0;
        timing_ok = 1'b0;
        case (bus.req_cmd)
            CmdAct: begin
                legal     = !bank_open_q[bank];
                timing_ok = (cnt_pre_q[bank] >= TRp) && (cnt_act_q[bank] >= TRc);
            end
            CmdRd, CmdWr: begin
                legal     = bank_open_q[bank];
                timing_ok = cnt_act_q[bank] >= TRcd;
            end
            default: begin
                legal     = bank_open_q[bank];
                timing_ok = (cnt_act_q[bank] >= TRas) && (cnt_rd_q[bank] >= TRtp) &&
                            (cnt_wr_q[bank] >= TWrec);
            end
        endcase
    end

    // Refresh may start once every bank is closed and past its precharge time
    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_open_q[i] || (cnt_pre_q[i] < TRp)) begin
                all_idle = 1'b0;
            end
        end
        ref_go = (state_q == StPending) && all_idle;
        // REF owns the slot; a pending refresh blocks new activations
        stall  = (state_q == StRefreshing) || ref_go ||
                 ((state_q == StPending) && (bus.req_cmd == CmdAct));
        // Illegal requests are consumed without waiting on timing
        accept = bus.req_valid && !stall && (!legal || timing_ok);
    end

    // Bank state, timing counters and issue register next-state
    always_comb begin
        bank_open_d   = bank_open_q;
        issue_valid_d = 1'b0;
        issue_cmd_d   = 3'd0;
        issue_bank_d  = '0;
        issue_row_d   = '0;
        err_illegal_d = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            cnt_act_d[i] = sat_inc(cnt_act_q[i]);
            cnt_pre_d[i] = sat_inc(cnt_pre_q[i]);
            cnt_rd_d[i]  = sat_inc(cnt_rd_q[i]);
            cnt_wr_d[i]  = sat_inc(cnt_wr_q[i]);
        end
        if (ref_go) begin
            issue_valid_d = 1'b1;
            issue_cmd_d   = IssRef;
        end else if (accept) begin
            if (legal) begin
                issue_valid_d = 1'b1;
                issue_cmd_d   = {1'b0, bus.req_cmd};
                issue_bank_d  = bank;
                case (bus.req_cmd)
                    CmdAct: begin
                        bank_open_d[bank] = 1'b1;
                        issue_row_d       = bus.req_row;
                        cnt_act_d[bank]   = CntOne;
                    end
                    CmdRd:   cnt_rd_d[bank] = CntOne;
                    CmdWr:   cnt_wr_d[bank] = CntOne;
                    default: begin
                        bank_open_d[bank] = 1'b0;
                        cnt_pre_d[bank]   = CntOne;
                    end
                endcase
            end else begin
                err_illegal_d = 1'b1;
            end
        end
    end

    // Refresh FSM: count tREFI, wait for banks to quiesce, then hold off for tRFC
    always_comb begin
        state_d = state_q;
        refi_d  = refi_q;
        rfc_d   = rfc_q;
        case (state_q)
            StIdle: begin
                refi_d = refi_q + 1'b1;
                if (refi_d >= TRefiM1) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (ref_go) begin
                    state_d = StRefreshing;
                    refi_d  = '0;
                    rfc_d   = TRfcM1;
                end
            end
            StRefreshing: begin
                refi_d = refi_q + 1'b1;
                if (rfc_q == '0) begin
                    state_d = StIdle;
                end else begin
                    rfc_d = rfc_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; counters reset saturated so the first command to a bank is unconstrained
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bank_open_q   <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                cnt_act_q[i] <= CntMax;
                cnt_pre_q[i] <= CntMax;
                cnt_rd_q[i]  <= CntMax;
                cnt_wr_q[i]  <= CntMax;
            end
            state_q       <= StIdle;
            refi_q        <= '0;
            rfc_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_cmd_q   <= 3'd0;
            issue_bank_q  <= '0;
            issue_row_q   <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            bank_open_q   <= bank_open_d;
            for (int i = 0; i < NUM_BANKS; i++) begin
                cnt_act_q[i] <= cnt_act_d[i];
                cnt_pre_q[i] <= cnt_pre_d[i];
                cnt_rd_q[i]  <= cnt_rd_d[i];
                cnt_wr_q[i]  <= cnt_wr_d[i];
            end
            state_q       <= state_d;
            refi_q        <= refi_d;
            rfc_q         <= rfc_d;
            issue_valid_q <= issue_valid_d;
            issue_cmd_q   <= issue_cmd_d;
            issue_bank_q  <= issue_bank_d;
            issue_row_q   <= issue_row_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign bus.req_ready   = accept;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_cmd   = issue_cmd_q;
    assign bus.issue_bank  = issue_bank_q;
    assign bus.issue_row   = issue_row_q;
    assign bus.bank_open   = bank_open_q;
    assign bus.ref_pending = (state_q == StPending);
    assign bus.ref_busy    = (state_q == StRefreshing);
    assign bus.err_illegal = err_illegal_q;
endmodule

// File: tb/tb_dram_bank_timing_ctrl.sv
// Bench for dram_bank_timing_ctrl: directed timing scenarios followed by random traffic,
// all checked against a timestamp-based reference model.
module tb_dram_bank_timing_ctrl;
    localparam int NB     = 16;
    localparam int RB     = 15;
    localparam int T_RCD  = 10;
    localparam int T_RAS  = 10;
    localparam int T_RP   = 10;
    localparam int T_RC   = 20;
    localparam int T_RTP  = 4;
    localparam int T_WREC = 26;
    localparam int T_REFI = 250;
    localparam int T_RFC  = 172;
    localparam int NEVER  = -100000;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    dram_bank_timing_ctrl_if #(.NUM_BANKS(NB), .ROW_BITS(RB)) bus ();

    dram_bank_timing_ctrl #(.NUM_BANKS(NB), .ROW_BITS(RB)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Reference model: absolute edge number of the last handshake of each command per bank
    int t_act [NB];
    int t_pre [NB];
    int t_rd  [NB];
    int t_wr  [NB];
    bit open_m [NB];
    int n;          // edges since reset release
    int ref_base;   // edge the refresh interval restarted from
    int ref_edge;   // edge of last REF handshake
    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        ref_base = 0;
        ref_edge = NEVER;
        for (int i = 0; i < NB; i++) begin
            t_act[i] = NEVER;
            t_pre[i] = NEVER;
            t_rd[i]  = NEVER;
            t_wr[i]  = NEVER;
            open_m[i] = 1'b0;
        end
    endtask

    // One clock: check req_ready mid-cycle, advance the model at the edge, check outputs after it
    task automatic step(output bit dut_rdy);
        bit busy, pend, go, legal, tok, exp_rdy;
        bit exp_iv, exp_err;
        int ne, b, c, row, exp_cmd, exp_bank, exp_row;
        logic [NB-1:0] exp_open;
        @(negedge CLK);
        ne   = n + 1;
        b    = int'(bus.req_bank);
        c    = int'(bus.req_cmd);
        row  = int'(bus.req_row);
        busy = (ref_edge != NEVER) && (n < ref_edge + T_RFC);
        pend = !busy && (n >= ref_base + T_REFI - 1);
        go   = pend;
        for (int i = 0; i < NB; i++) begin
            if (open_m[i] || (ne - t_pre[i] < T_RP)) go = 1'b0;
        end
        if (c == 0) begin
            legal = !open_m[b];
            tok   = (ne - t_pre[b] >= T_RP) && (ne - t_act[b] >= T_RC);
        end else if (c == 1 || c == 2) begin
            legal = open_m[b];
            tok   = (ne - t_act[b] >= T_RCD);
        end else begin
            legal = open_m[b];
            tok   = (ne - t_act[b] >= T_RAS) && (ne - t_rd[b] >= T_RTP) &&
                    (ne - t_wr[b] >= T_WREC);
        end
        exp_rdy = bus.req_valid && !busy && !go && !(pend && c == 0) && (!legal || tok);
        dut_rdy = bus.req_ready;
        chk(dut_rdy, exp_rdy, "req_ready");
        @(posedge CLK);
        n = ne;
        exp_iv = 0; exp_err = 0; exp_cmd = 0; exp_bank = 0; exp_row = 0;
        if (go) begin
            exp_iv   = 1;
            exp_cmd  = 4;
            ref_base = ne;
            ref_edge = ne;
        end else if (exp_rdy) begin
            if (legal) begin
                exp_iv   = 1;
                exp_cmd  = c;
                exp_bank = b;
                case (c)
                    0: begin open_m[b] = 1'b1; t_act[b] = ne; exp_row = row; end
                    1: t_rd[b] = ne;
                    2: t_wr[b] = ne;
                    default: begin open_m[b] = 1'b0; t_pre[b] = ne; end
                endcase
            end else begin
                exp_err = 1;
            end
        end
        for (int i = 0; i < NB; i++) exp_open[i] = open_m[i];
        busy = (ref_edge != NEVER) && (n < ref_edge + T_RFC);
        pend = !busy && (n >= ref_base + T_REFI - 1);
        #1;
        chk(bus.issue_valid, exp_iv, "issue_valid");
        chk(bus.issue_cmd, exp_cmd, "issue_cmd");
        chk(bus.issue_bank, exp_bank, "issue_bank");
        chk(bus.issue_row, exp_row, "issue_row");
        chk(bus.err_illegal, exp_err, "err_illegal");
        chk(bus.bank_open, exp_open, "bank_open");
        chk(bus.ref_pending, pend, "ref_pending");
        chk(bus.ref_busy, busy, "ref_busy");
    endtask

    task automatic idle();
        bit r;
        bus.req_valid = 1'b0;
        step(r);
    endtask

    // Hold a request until the DUT accepts it; returns the handshake edge
    task automatic send(input int cmd, input int bank, input int row, output int acc_edge);
        bit r;
        int k;
        bus.req_valid = 1'b1;
        bus.req_cmd   = 2'(cmd);
        bus.req_bank  = 4'(bank);
        bus.req_row   = 15'(row);
        r = 0;
        k = 0;
        while (!r && k < 64) begin
            step(r);
            k++;
        end
        chk(r, 1, "send_accepted");
        bus.req_valid = 1'b0;
        acc_edge = n;
    endtask

    task automatic wait_pending(input int max_cycles);
        int k;
        k = 0;
        while (bus.ref_pending !== 1'b1 && k < max_cycles) begin
            idle();
            k++;
        end
        chk(bus.ref_pending, 1, "pending_seen");
    endtask

    initial begin
        int e0, e1, s, ref_e, p, cnt, k;
        bit r, got;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 2'd0;
        bus.req_bank  = 4'd0;
        bus.req_row   = 15'd0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk(bus.issue_valid, 0, "rst_issue_valid");
        chk(bus.bank_open, 0, "rst_bank_open");
        chk(bus.ref_pending, 0, "rst_ref_pending");
        chk(bus.ref_busy, 0, "rst_ref_busy");
        chk(bus.err_illegal, 0, "rst_err_illegal");
        nRST = 1'b1;

        // ACT then RD held off by tRCD
        send(0, 3, 'h1234, e0);
        chk(e0, 1, "act3_first_edge");
        chk(bus.issue_cmd, 0, "act3_cmd");
        chk(bus.issue_row, 'h1234, "act3_row");
        chk(bus.bank_open, 'h0008, "act3_open");
        send(1, 3, 0, e1);
        chk(e1 - e0, T_RCD, "trcd_gap");
        chk(bus.issue_cmd, 1, "rd3_cmd");

        // ACT -> PRE (tRAS) -> ACT (tRC / tRP)
        send(0, 0, 'h0055, e0);
        idle();
        send(3, 0, 0, e1);
        chk(e1 - e0, T_RAS, "tras_gap");
        send(0, 0, 'h0066, e1);
        chk(e1 - e0, T_RC, "trc_gap");

        // Write recovery and read-to-precharge
        send(0, 1, 'h0101, e0);
        send(0, 2, 'h0202, e0);
        send(2, 1, 0, e0);
        send(1, 2, 0, e1);
        send(3, 2, 0, s);
        chk(s - e1, T_RTP, "trtp_gap");
        send(3, 1, 0, s);
        chk(s - e0, T_WREC, "twrec_gap");

        // Illegal requests are consumed immediately
        s = n;
        send(1, 5, 0, e0);
        chk(e0 - s, 1, "illegal_rd_latency");
        chk(bus.err_illegal, 1, "illegal_rd_err");
        chk(bus.issue_valid, 0, "illegal_rd_noissue");
        chk(bus.bank_open, 'h0009, "illegal_rd_open");
        s = n;
        send(0, 3, 'h0777, e0);
        chk(e0 - s, 1, "illegal_act_latency");
        chk(bus.err_illegal, 1, "illegal_act_err");
        chk(bus.bank_open, 'h0009, "illegal_act_open");
        idle();
        chk(bus.err_illegal, 0, "err_one_cycle");

        // Refresh with all banks idle
        send(3, 0, 0, e0);
        send(3, 3, 0, e0);
        wait_pending(300);
        chk(n, T_REFI - 1, "ref_pending_edge");
        idle();
        ref_e = n;
        chk(bus.issue_valid, 1, "ref_issue_valid");
        chk(bus.issue_cmd, 4, "ref_issue_cmd");
        chk(bus.ref_busy, 1, "ref_busy_set");
        chk(ref_e, T_REFI, "ref_issue_edge");
        cnt = 0;
        while (bus.ref_busy === 1'b1 && cnt < 400) begin
            bus.req_valid = 1'b1;
            bus.req_cmd   = 2'd0;
            bus.req_bank  = 4'd6;
            step(r);
            cnt++;
        end
        bus.req_valid = 1'b0;
        chk(cnt, T_RFC, "ref_busy_len");

        // Refresh held off by an open bank
        send(0, 7, 'h0707, e0);
        wait_pending(300);
        chk(n - ref_e, T_REFI - 1, "ref_pending_period");
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_cmd   = 2'd0;
            bus.req_bank  = 4'd2;
            step(r);
            chk(r, 0, "act_stalled_pending");
        end
        send(3, 7, 0, p);
        got = 0;
        k = 0;
        while (!got && k < 40) begin
            idle();
            k++;
            got = (bus.issue_valid === 1'b1) && (bus.issue_cmd === 3'd4);
        end
        chk(got, 1, "ref2_seen");
        chk(n - p, T_RP, "ref2_after_pre");
        repeat (3) idle();

        // Asynchronous reset in the middle of tRFC
        #3;
        nRST = 1'b0;
        #1;
        chk(bus.ref_busy, 0, "arst_ref_busy");
        chk(bus.ref_pending, 0, "arst_ref_pending");
        chk(bus.issue_valid, 0, "arst_issue_valid");
        chk(bus.issue_cmd, 0, "arst_issue_cmd");
        chk(bus.bank_open, 0, "arst_bank_open");
        chk(bus.err_illegal, 0, "arst_err");
        @(posedge CLK);
        #1;
        model_reset();
        nRST = 1'b1;

        // Random traffic concentrated on a few banks
        for (int i = 0; i < 2500; i++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_cmd   = 2'($urandom_range(0, 3));
            bus.req_bank  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(0, 3));
            bus.req_row   = 15'($urandom);
            step(r);
        end
        bus.req_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
